// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT frame sequencer.
// Holds the processor state enum, sample width and default frame length.
package fft_pkg;
  localparam int FFT_SAMPLE_W = 32;
  localparam int FFT_N = 32;

  typedef enum logic [1:0] {
    P_IDLE,
    P_FFT,
    P_OUT
  } fft_proc_state_t;
endpackage

// File: rtl/fft_decim_ctr.sv
// Sample decimator: accepts one of every DECIM strobes, starting with the first.
// Ports: clk, reset_n (async low), strobe in, accept out (combinational).
module fft_decim_ctr #(
  parameter int DECIM = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic strobe,
  output logic accept
);
  localparam int CW = 5;

  logic [CW-1:0] cnt_q, cnt_d;

  assign accept = strobe && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (strobe) begin
      cnt_d = (cnt_q == CW'(DECIM - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/fft_frame_sequencer.sv
// Ping-pong frame writer plus FFT/readout sequencer; drops frames on overrun.
// Ports: sample in/valid, buffer write port, fft/out handshakes, busy, overrun,
// and ovf_count (only when FFT_SEQ_OVF_CNT_EN is defined).
module fft_frame_sequencer
  import fft_pkg::*;
#(
  parameter int N     = FFT_N,
  parameter int AW    = $clog2(N),
  parameter int DECIM = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [FFT_SAMPLE_W-1:0] sample_in,
  input  logic                    sample_valid,
  output logic                    buf_we,
  output logic [AW:0]             buf_waddr,
  output logic [FFT_SAMPLE_W-1:0] buf_wdata,
  output logic                    fft_start,
  output logic                    fft_bank,
  input  logic                    fft_done,
  output logic                    out_start,
  input  logic                    out_done,
  output logic                    busy,
  output logic                    overrun
`ifdef FFT_SEQ_OVF_CNT_EN
  ,
  output logic [15:0]             ovf_count
`endif
);
  logic accept;

  fft_decim_ctr #(.DECIM(DECIM)) u_decim (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  (sample_valid),
    .accept  (accept)
  );

  fft_proc_state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic wbank_q, wbank_d;
  logic last_q, last_d;
  logic fbank_q, fbank_d;
  logic we_q, start_q, ostart_q, busy_q, ovr_q;
  logic ovr_d, handoff;
  logic [AW:0] waddr_q;
  logic [FFT_SAMPLE_W-1:0] wdata_q;

  // last_q marks the cycle in which the frame's final write is on buf_we;
  // the handoff decision is made then, and an accept in that same cycle
  // must already see the toggled bank (full-rate strobes).
  always_comb begin
    handoff = last_q && (state_q == P_IDLE ||
                         (state_q == P_OUT && out_done));
    ovr_d   = last_q && !handoff;
    wbank_d = wbank_q ^ handoff;
    fbank_d = handoff ? wbank_q : fbank_q;
    idx_d   = accept ? idx_q + 1'b1 : idx_q;
    last_d  = accept && (idx_q == AW'(N - 1));
    state_d = state_q;
    unique case (state_q)
      P_IDLE:  state_d = P_IDLE;
      P_FFT:   if (fft_done) state_d = P_OUT;
      P_OUT:   if (out_done) state_d = P_IDLE;
      default: state_d = P_IDLE;
    endcase
    if (handoff) state_d = P_FFT;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= P_IDLE;
      idx_q    <= '0;
      wbank_q  <= 1'b0;
      last_q   <= 1'b0;
      fbank_q  <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      start_q  <= 1'b0;
      ostart_q <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wbank_q  <= wbank_d;
      last_q   <= last_d;
      fbank_q  <= fbank_d;
      we_q     <= accept;
      if (accept) begin
        waddr_q <= {wbank_d, idx_q};
        wdata_q <= sample_in;
      end
      start_q  <= handoff;
      ostart_q <= (state_q == P_FFT) && fft_done;
      busy_q   <= (state_d != P_IDLE);
      ovr_q    <= ovr_d;
    end
  end

  assign buf_we    = we_q;
  assign buf_waddr = waddr_q;
  assign buf_wdata = wdata_q;
  assign fft_start = start_q;
  assign fft_bank  = fbank_q;
  assign out_start = ostart_q;
  assign busy      = busy_q;
  assign overrun   = ovr_q;

`ifdef FFT_SEQ_OVF_CNT_EN
  logic [15:0] ovf_q;

  // Counted from ovr_d so the count moves with the overrun pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        ovf_q <= '0;
    else if (ovr_d && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 1'b1;
  end

  assign ovf_count = ovf_q;
`endif
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer (N=8; DECIM=1 and DECIM=4 instances).
// Optional ovf_count checks follow FFT_SEQ_OVF_CNT_EN.
module tb_fft_frame_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic [31:0] sin = '0;
  logic sv = 1'b0, fdone = 1'b0, odone = 1'b0;
  logic we, fstart, fbank, ostart, busy, ovr;
  logic [3:0] waddr;
  logic [31:0] wdata;

  logic [31:0] sin4 = '0;
  logic sv4 = 1'b0;
  logic we4, fstart4, fbank4, ostart4, busy4, ovr4;
  logic [3:0] waddr4;
  logic [31:0] wdata4;

`ifdef FFT_SEQ_OVF_CNT_EN
  logic [15:0] ovf, ovf4;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fft_frame_sequencer #(.N(8), .DECIM(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .sample_in(sin), .sample_valid(sv),
    .buf_we(we), .buf_waddr(waddr), .buf_wdata(wdata),
    .fft_start(fstart), .fft_bank(fbank), .fft_done(fdone),
    .out_start(ostart), .out_done(odone),
    .busy(busy), .overrun(ovr)
`ifdef FFT_SEQ_OVF_CNT_EN
    , .ovf_count(ovf)
`endif
  );

  fft_frame_sequencer #(.N(8), .DECIM(4)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .sample_in(sin4), .sample_valid(sv4),
    .buf_we(we4), .buf_waddr(waddr4), .buf_wdata(wdata4),
    .fft_start(fstart4), .fft_bank(fbank4), .fft_done(1'b0),
    .out_start(ostart4), .out_done(1'b0),
    .busy(busy4), .overrun(ovr4)
`ifdef FFT_SEQ_OVF_CNT_EN
    , .ovf_count(ovf4)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [31:0] d);
    sin = d;
    sv = 1'b1;
    tick();
    sv = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    n_cmp++;
    if ({we, waddr, wdata, fstart, fbank, ostart, busy, ovr} !== '0) begin
      n_bad++;
      $display("FAIL reset_outs: got we=%b addr=%0d data=%h st=%b bk=%b os=%b busy=%b ovr=%b want all 0",
               we, waddr, wdata, fstart, fbank, ostart, busy, ovr);
    end
    n_cmp++;
    if ({we4, waddr4, wdata4, fstart4, fbank4, ostart4, busy4, ovr4} !== '0) begin
      n_bad++;
      $display("FAIL reset_outs4: got nonzero outputs, want all 0");
    end
`ifdef FFT_SEQ_OVF_CNT_EN
    n_cmp++;
    if (ovf !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_ovf: got %0d want 0", ovf);
    end
`endif
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_frame();
    for (int i = 0; i < 8; i++) begin
      strobe(32'd100 + i);
      n_cmp++;
      if ({we, waddr, wdata, fstart} !== {1'b1, 4'(i), 32'd100 + i, 1'b0}) begin
        n_bad++;
        $display("FAIL basic_wr%0d: got we=%b addr=%0d data=%0d st=%b want 1/%0d/%0d/0",
                 i, we, waddr, wdata, fstart, i, 100 + i);
      end
      if (i < 7) repeat (15) tick();
    end
    // next sample at full rate, in the same cycle the handoff is decided
    strobe(32'd200);
    n_cmp++;
    if ({we, waddr, wdata, fstart, fbank, busy} !== {1'b1, 4'd8, 32'd200, 3'b101}) begin
      n_bad++;
      $display("FAIL basic_handoff: got addr=%0d data=%0d st=%b bk=%b busy=%b want 8/200/1/0/1",
               waddr, wdata, fstart, fbank, busy);
    end
    tick();
    n_cmp++;
    if (fstart !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_start_pulse: got %b want 0", fstart);
    end
  endtask

  task automatic test_sequencing();
    repeat (18) tick();
    fdone = 1'b1;
    tick();
    fdone = 1'b0;
    n_cmp++;
    if ({ostart, busy} !== 2'b11) begin
      n_bad++;
      $display("FAIL seq_out_start: got os=%b busy=%b want 1/1", ostart, busy);
    end
    tick();
    n_cmp++;
    if ({ostart, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL seq_out_pulse: got os=%b busy=%b want 0/1", ostart, busy);
    end
    repeat (18) tick();
    odone = 1'b1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL seq_busy_hi: got %b want 1", busy);
    end
    tick();
    odone = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL seq_busy_lo: got %b want 0", busy);
    end
    fdone = 1'b1;
    tick();
    fdone = 1'b0;
    n_cmp++;
    if ({ostart, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL seq_stray_done: got os=%b busy=%b want 0/0", ostart, busy);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      strobe(32'd300 + i);
      n_cmp++;
      if ({we, waddr} !== {1'b1, 4'(i)}) begin
        n_bad++;
        $display("FAIL ovr_f1_wr%0d: got we=%b addr=%0d want 1/%0d", i, we, waddr, i);
      end
      repeat (3) tick();
    end
    n_cmp++;
    if ({busy, fbank, ovr} !== 3'b100) begin
      n_bad++;
      $display("FAIL ovr_f1_busy: got busy=%b bk=%b ovr=%b want 1/0/0", busy, fbank, ovr);
    end
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) begin
        strobe(32'd400 + 16 * f + i);
        n_cmp++;
        if ({we, waddr, wdata, fstart, ovr} !== {1'b1, 4'd8 + 4'(i), 32'd400 + 16 * f + i, 2'b00}) begin
          n_bad++;
          $display("FAIL ovr_f%0d_wr%0d: got we=%b addr=%0d data=%0d st=%b ovr=%b want addr=%0d",
                   f + 2, i, we, waddr, wdata, fstart, ovr, 8 + i);
        end
      end
      tick();
      n_cmp++;
      if ({ovr, fstart, we} !== 3'b100) begin
        n_bad++;
        $display("FAIL ovr_pulse%0d: got ovr=%b st=%b we=%b want 1/0/0", f, ovr, fstart, we);
      end
`ifdef FFT_SEQ_OVF_CNT_EN
      n_cmp++;
      if (ovf !== 16'(f + 1)) begin
        n_bad++;
        $display("FAIL ovr_count%0d: got %0d want %0d", f, ovf, f + 1);
      end
`endif
      tick();
      n_cmp++;
      if (ovr !== 1'b0) begin
        n_bad++;
        $display("FAIL ovr_once%0d: got %b want 0", f, ovr);
      end
    end
    n_cmp++;
    if ({busy, fbank} !== 2'b10) begin
      n_bad++;
      $display("FAIL ovr_hold: got busy=%b bk=%b want 1/0", busy, fbank);
    end
  endtask

  task automatic test_boundary_handoff();
    fdone = 1'b1;
    tick();
    fdone = 1'b0;
    n_cmp++;
    if (ostart !== 1'b1) begin
      n_bad++;
      $display("FAIL bnd_out_start: got %b want 1", ostart);
    end
    for (int i = 0; i < 8; i++) begin
      strobe(32'd600 + i);
      if (i == 7) odone = 1'b1;
      n_cmp++;
      if ({we, waddr, wdata} !== {1'b1, 4'd8 + 4'(i), 32'd600 + i}) begin
        n_bad++;
        $display("FAIL bnd_wr%0d: got addr=%0d data=%0d want %0d/%0d",
                 i, waddr, wdata, 8 + i, 600 + i);
      end
      if (i < 7) repeat (2) tick();
    end
    tick();
    odone = 1'b0;
    n_cmp++;
    if ({fstart, ovr, fbank, busy} !== 4'b1011) begin
      n_bad++;
      $display("FAIL bnd_handoff: got st=%b ovr=%b bk=%b busy=%b want 1/0/1/1",
               fstart, ovr, fbank, busy);
    end
    strobe(32'd700);
    n_cmp++;
    if ({we, waddr} !== {1'b1, 4'd0}) begin
      n_bad++;
      $display("FAIL bnd_next_bank: got we=%b addr=%0d want 1/0", we, waddr);
    end
  endtask

  task automatic test_decimation();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      sin4 = 32'(i);
      sv4 = 1'b1;
      tick();
      sv4 = 1'b0;
      n_cmp++;
      if (i % 4 == 0) begin
        if ({we4, waddr4, wdata4} !== {1'b1, 4'(i / 4), 32'(i)}) begin
          n_bad++;
          $display("FAIL decim_wr%0d: got we=%b addr=%0d data=%0d want 1/%0d/%0d",
                   i, we4, waddr4, wdata4, i / 4, i);
        end
      end else if (we4 !== 1'b0) begin
        n_bad++;
        $display("FAIL decim_skip%0d: got we=%b want 0", i, we4);
      end
      tick();
      if (i == 28) begin
        n_cmp++;
        if ({fstart4, fbank4} !== 2'b10) begin
          n_bad++;
          $display("FAIL decim_start: got st=%b bk=%b want 1/0", fstart4, fbank4);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      strobe(32'd800 + i);
      n_cmp++;
      if ({we, waddr} !== {1'b1, 4'(i)}) begin
        n_bad++;
        $display("FAIL rmf_pre%0d: got we=%b addr=%0d want 1/%0d", i, we, waddr, i);
      end
      tick();
    end
    sv = 1'b1;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({we, waddr, wdata, fstart, fbank, ostart, busy, ovr} !== '0) begin
      n_bad++;
      $display("FAIL rmf_async: got we=%b addr=%0d data=%h want all 0", we, waddr, wdata);
    end
    tick();
    tick();
    n_cmp++;
    if ({we, waddr, wdata, fstart, fbank, ostart, busy, ovr} !== '0) begin
      n_bad++;
      $display("FAIL rmf_held: got we=%b addr=%0d data=%h want all 0", we, waddr, wdata);
    end
    sv = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      strobe(32'd900 + i);
      n_cmp++;
      if ({we, waddr, fstart} !== {1'b1, 4'(i), 1'b0}) begin
        n_bad++;
        $display("FAIL rmf_post%0d: got we=%b addr=%0d st=%b want 1/%0d/0", i, we, waddr, fstart, i);
      end
      tick();
      n_cmp++;
      if (fstart !== (i == 7)) begin
        n_bad++;
        $display("FAIL rmf_start%0d: got %b want %b", i, fstart, i == 7);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_sequencing();
    test_overrun();
    test_boundary_handoff();
    test_decimation();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
